// File: rtl/pattern_sweep_capture_pkg.sv
// Shared types and constants for the pattern sweep / response capture block.
package pattern_sweep_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [15:0] DEFAULT_POLY = 16'h1021;

   function automatic logic [15:0] to_gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/pattern_sweep_capture_misr.sv
// Multiple-input signature register compacting the sampled DUT responses.
module misr_compactor
   import pattern_sweep_capture_pkg::*;
#(
   parameter int               SIG_W = 16,
   parameter int               OUT_W = 1,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [OUT_W-1:0] din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] r_sig;

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [OUT_W-1:0] d);
      return (s << 1) ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ SIG_W'(d);
   endfunction

   // Signature register: clear has priority over an update.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         r_sig <= {SIG_W{1'b0}};
      end else if (clr) begin
         r_sig <= {SIG_W{1'b0}};
      end else if (en) begin
         r_sig <= misr_step(r_sig, din);
      end else begin
         r_sig <= r_sig;
      end
   end

   assign sig = r_sig;

endmodule

// File: rtl/pattern_sweep_capture.sv
// Sweeps every IN_W-bit stimulus pattern (binary or Gray order), samples the
// DUT response after a settle delay, logs it and folds it into a signature.
module pattern_sweep_capture
   import pattern_sweep_capture_pkg::*;
#(
   parameter int               IN_W   = 6,
   parameter int               OUT_W  = 1,
   parameter int               SETTLE = 1,
   parameter int               SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY)
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic [OUT_W-1:0] dut_out,
   output logic [IN_W-1:0]  pattern,
   output logic             cap_valid,
   output logic [IN_W-1:0]  cap_pattern,
   output logic [OUT_W-1:0] cap_data,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature
);

   // Index is one bit wider than the pattern so the last pattern never aliases to 0.
   localparam logic [IN_W:0] LAST_IDX   = (IN_W+1)'((1 << IN_W) - 1);
   localparam logic [7:0]    SETTLE_CNT = 8'(SETTLE);

   state_t            r_state;
   state_t            w_state_next;
   logic [IN_W:0]     r_idx;
   logic [IN_W:0]     w_idx_inc;
   logic [7:0]        r_settle;
   logic              r_mode;
   logic [IN_W-1:0]   r_pattern;
   logic [IN_W-1:0]   w_pat_next;
   logic              r_cap_valid;
   logic [IN_W-1:0]   r_cap_pattern;
   logic [OUT_W-1:0]  r_cap_data;
   logic              r_busy;
   logic              r_done;
   logic              w_accept;
   logic              w_sample;
   logic              w_advance;
   logic [SIG_W-1:0]  w_sig;

   // FSM state register.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic; abort overrides both start and normal sequencing.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start && !abort) w_state_next = ST_APPLY;
            else                 w_state_next = r_state;
         end
         ST_APPLY: begin
            if (abort)                        w_state_next = ST_IDLE;
            else if (r_settle == SETTLE_CNT)  w_state_next = ST_SAMPLE;
            else                              w_state_next = ST_APPLY;
         end
         ST_SAMPLE: begin
            if (abort)                 w_state_next = ST_IDLE;
            else if (r_idx == LAST_IDX) w_state_next = ST_DONE;
            else                        w_state_next = ST_APPLY;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM control decodes.
   always_comb begin
      w_accept  = 1'b0;
      w_sample  = 1'b0;
      w_advance = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            w_accept = start && !abort;
         end
         ST_SAMPLE: begin
            w_sample  = !abort;
            w_advance = !abort && (r_idx != LAST_IDX);
         end
         default: begin
            w_accept  = 1'b0;
            w_sample  = 1'b0;
            w_advance = 1'b0;
         end
      endcase
   end

   assign w_idx_inc  = r_idx + (IN_W+1)'(1);
   assign w_pat_next = r_mode ? IN_W'(to_gray(16'(w_idx_inc))) : IN_W'(w_idx_inc);

   // Sweep datapath and registered outputs.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         r_idx         <= {(IN_W+1){1'b0}};
         r_settle      <= 8'd0;
         r_mode        <= 1'b0;
         r_pattern     <= {IN_W{1'b0}};
         r_cap_valid   <= 1'b0;
         r_cap_pattern <= {IN_W{1'b0}};
         r_cap_data    <= {OUT_W{1'b0}};
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         if (w_accept) begin
            r_idx  <= {(IN_W+1){1'b0}};
            r_mode <= mode;
         end else if (w_advance) begin
            r_idx  <= w_idx_inc;
         end

         if (r_state == ST_APPLY && w_state_next == ST_APPLY) r_settle <= r_settle + 8'd1;
         else                                                  r_settle <= 8'd0;

         if (w_advance)
            r_pattern <= w_pat_next;
         else if (w_state_next == ST_APPLY || w_state_next == ST_SAMPLE)
            r_pattern <= r_pattern;
         else
            r_pattern <= {IN_W{1'b0}};

         r_cap_valid <= w_sample;
         if (w_sample) begin
            r_cap_pattern <= r_pattern;
            r_cap_data    <= dut_out;
         end

         r_busy <= (w_state_next == ST_APPLY) || (w_state_next == ST_SAMPLE);
         r_done <= (w_state_next == ST_DONE);
      end
   end

   misr_compactor #(
      .SIG_W (SIG_W),
      .OUT_W (OUT_W),
      .POLY  (POLY)
   ) u_misr (
      .CK    (CK),
      .reset (reset),
      .clr   (w_accept),
      .en    (w_sample),
      .din   (dut_out),
      .sig   (w_sig)
   );

   assign pattern     = r_pattern;
   assign cap_valid   = r_cap_valid;
   assign cap_pattern = r_cap_pattern;
   assign cap_data    = r_cap_data;
   assign busy        = r_busy;
   assign done        = r_done;
   assign signature   = w_sig;

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Directed bench for pattern_sweep_capture using three parameterisations.
module tb_pattern_sweep_capture;

   logic CK;
   logic reset;
   int   n_tests;
   int   n_fail;

   // u0: IN_W=6, SETTLE=1
   logic start0, abort0, mode0, dout0;
   logic [5:0] pat0, cp0;
   logic cv0, cd0, busy0, done0;
   logic [15:0] sig0;
   // u1: IN_W=1, SETTLE=0
   logic start1, abort1, mode1, dout1;
   logic [0:0] pat1, cp1;
   logic cv1, cd1, busy1, done1;
   logic [15:0] sig1;
   // u2: IN_W=3, OUT_W=3, SETTLE=3
   logic start2, abort2, mode2;
   logic [2:0] dout2, pat2, cp2, cd2;
   logic cv2, busy2, done2;
   logic [15:0] sig2;

   assign dout2 = pat2 ^ 3'b101;

   pattern_sweep_capture #(.IN_W(6), .OUT_W(1), .SETTLE(1)) u0 (
      .CK(CK), .reset(reset), .start(start0), .abort(abort0), .mode(mode0),
      .dut_out(dout0), .pattern(pat0), .cap_valid(cv0), .cap_pattern(cp0),
      .cap_data(cd0), .busy(busy0), .done(done0), .signature(sig0));

   pattern_sweep_capture #(.IN_W(1), .OUT_W(1), .SETTLE(0)) u1 (
      .CK(CK), .reset(reset), .start(start1), .abort(abort1), .mode(mode1),
      .dut_out(dout1), .pattern(pat1), .cap_valid(cv1), .cap_pattern(cp1),
      .cap_data(cd1), .busy(busy1), .done(done1), .signature(sig1));

   pattern_sweep_capture #(.IN_W(3), .OUT_W(3), .SETTLE(3)) u2 (
      .CK(CK), .reset(reset), .start(start2), .abort(abort2), .mode(mode2),
      .dut_out(dout2), .pattern(pat2), .cap_valid(cv2), .cap_pattern(cp2),
      .cap_data(cd2), .busy(busy2), .done(done2), .signature(sig2));

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [15:0] d);
      return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
   endfunction

   function automatic logic [15:0] sig_const(input int n, input logic [15:0] d);
      logic [15:0] s;
      s = 16'h0000;
      for (int i = 0; i < n; i++) s = sig_step(s, d);
      return s;
   endfunction

   // Full u0 sweep in mode 0; optionally pulses start while busy at step inject_at.
   task automatic sweep_u0(input string tag, input int inject_at, input logic [15:0] exp_sig);
      int k;
      int ncap;
      @(negedge CK) start0 = 1'b1;
      @(negedge CK) start0 = 1'b0;
      k = 0;
      ncap = 0;
      chk({tag, "_sig_cleared"}, sig0, 32'h0);
      chk({tag, "_busy_after_start"}, busy0, 32'h1);
      chk({tag, "_first_pattern"}, pat0, 32'h0);
      do begin
         if (k == inject_at) start0 = 1'b1;
         @(negedge CK);
         start0 = 1'b0;
         k++;
         if (cv0) begin
            chk({tag, "_cap_order"}, cp0, ncap);
            ncap++;
         end
      end while (!done0 && k < 1000);
      chk({tag, "_done"}, done0, 32'h1);
      chk({tag, "_done_latency"}, k, 32'd192);
      chk({tag, "_cap_count"}, ncap, 32'd64);
      chk({tag, "_signature"}, sig0, exp_sig);
      chk({tag, "_pattern_idle"}, pat0, 32'h0);
      chk({tag, "_busy_done"}, busy0, 32'h0);
      repeat (3) @(negedge CK);
      chk({tag, "_sig_stable"}, sig0, exp_sig);
      chk({tag, "_done_held"}, done0, 32'h1);
   endtask

   initial begin
      int k;
      int nc;
      int first;
      int prevk;
      logic [2:0]  gray_tbl [8];
      logic [15:0] msig;

      n_tests = 0;
      n_fail  = 0;
      gray_tbl = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
      reset = 1'b1;
      {start0, abort0, mode0, dout0} = 4'b0000;
      {start1, abort1, mode1} = 3'b000;
      dout1 = 1'b1;
      {start2, abort2, mode2} = 3'b000;

      #12;
      chk("rst_pattern", pat0, 32'h0);
      chk("rst_busy", busy0, 32'h0);
      chk("rst_done", done0, 32'h0);
      chk("rst_cap_valid", cv0, 32'h0);
      chk("rst_signature", sig2, 32'h0);
      @(negedge CK) reset = 1'b0;
      repeat (2) @(negedge CK);
      chk("idle_no_activity", busy0, 32'h0);

      // Binary sweep, zero response.
      sweep_u0("bin", -1, 16'h0000);

      // IN_W=1, constant response 1, SETTLE=0.
      @(negedge CK) start1 = 1'b1;
      @(negedge CK) start1 = 1'b0;
      k = 0; nc = 0; first = 0;
      do begin
         @(negedge CK);
         k++;
         if (cv1) begin
            if (nc == 0) begin
               chk("w1_sig_first", sig1, 32'h0001);
               first = k;
            end else begin
               chk("w1_spacing", k - first, 32'd2);
            end
            nc++;
         end
      end while (!done1 && k < 100);
      chk("w1_sig_done", sig1, 32'h0003);
      chk("w1_done_latency", k, 32'd4);
      chk("w1_cap_count", nc, 32'd2);

      // Gray sweep, IN_W=3, SETTLE=3; mode flipped mid-sweep must be ignored.
      @(negedge CK) begin start2 = 1'b1; mode2 = 1'b1; end
      @(negedge CK) begin start2 = 1'b0; mode2 = 1'b0; end
      k = 0; nc = 0; prevk = 0; msig = 16'h0000;
      chk("g_pattern_start", pat2, 32'h0);
      do begin
         @(negedge CK);
         k++;
         if (cv2) begin
            chk("g_cap_pattern", cp2, gray_tbl[nc]);
            chk("g_cap_data", cd2, gray_tbl[nc] ^ 3'b101);
            if (nc > 0) chk("g_spacing", k - prevk, 32'd5);
            msig = sig_step(msig, {13'd0, gray_tbl[nc] ^ 3'b101});
            prevk = k;
            nc++;
         end
         if (busy2 && nc < 8) chk("g_pattern_hold", pat2, gray_tbl[nc]);
      end while (!done2 && k < 200);
      chk("g_done_latency", k, 32'd40);
      chk("g_cap_count", nc, 32'd8);
      chk("g_signature", sig2, msig);

      // Abort during pattern 5 with response 1.
      dout0 = 1'b1;
      @(negedge CK) start0 = 1'b1;
      @(negedge CK) start0 = 1'b0;
      k = 0;
      while (pat0 != 6'd5 && k < 100) begin
         @(negedge CK);
         k++;
      end
      chk("ab_reach_p5", pat0, 32'd5);
      abort0 = 1'b1;
      @(negedge CK) abort0 = 1'b0;
      chk("ab_busy", busy0, 32'h0);
      chk("ab_done", done0, 32'h0);
      chk("ab_pattern", pat0, 32'h0);
      chk("ab_no_cap", cv0, 32'h0);
      chk("ab_sig_kept", sig0, 32'h001F);
      // start together with abort must be refused
      {start0, abort0} = 2'b11;
      @(negedge CK) {start0, abort0} = 2'b00;
      chk("ab_start_refused", busy0, 32'h0);
      chk("ab_sig_after_refuse", sig0, 32'h001F);
      sweep_u0("restart", 10, sig_const(64, 16'h0001));

      // Asynchronous reset in the middle of APPLY.
      @(negedge CK) start0 = 1'b1;
      @(negedge CK) start0 = 1'b0;
      k = 0;
      while (pat0 != 6'd3 && k < 100) begin
         @(negedge CK);
         k++;
      end
      chk("ar_reach_p3", pat0, 32'd3);
      #2 reset = 1'b1;
      #1;
      chk("ar_pattern", pat0, 32'h0);
      chk("ar_busy", busy0, 32'h0);
      chk("ar_cap_pattern", cp0, 32'h0);
      chk("ar_cap_data", cd0, 32'h0);
      chk("ar_signature", sig0, 32'h0);
      chk("ar_done", done0, 32'h0);
      #1 reset = 1'b0;
      repeat (3) @(negedge CK);
      chk("ar_stay_idle", busy0, 32'h0);
      chk("ar_no_cap", cv0, 32'h0);
      sweep_u0("post_rst", -1, sig_const(64, 16'h0001));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_sweep_capture.md
PATTERN_SWEEP_CAPTURE -- requirements
Module: pattern_sweep_capture

Interface
REQ-001 Parameter IN_W, default 6, width of the stimulus vector driven to the device under test (DUT) (1..16).
REQ-002 Parameter OUT_W, default 1, width of the DUT response vector (1..SIG_W).
REQ-003 Parameter SETTLE, default 1, extra hold cycles between applying a pattern and sampling the response (0..255).
REQ-004 Parameter SIG_W, default 16, width of the response signature register.
REQ-005 Parameter POLY, default 16'h1021, signature feedback polynomial (SIG_W bits).
REQ-006 CK  input  1  the single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
REQ-009 abort  input  1  terminate a running sweep.
REQ-010 mode  input  1  0 = ascending binary order, 1 = Gray-code order.
REQ-011 dut_out  input  OUT_W  DUT response.
REQ-012 pattern  output  IN_W  stimulus to DUT.
REQ-013 cap_valid  output  1  one-cycle strobe: cap_pattern/cap_data are valid for logging.
REQ-014 cap_pattern  output  IN_W  pattern associated with the sampled response.
REQ-015 cap_data  output  OUT_W  sampled response.
REQ-016 busy  output  1  high in APPLY or SAMPLE.
REQ-017 done  output  1  high while in DONE.
REQ-018 signature  output  SIG_W  compacted response signature.

Function
REQ-019 FSM states: IDLE, APPLY, SAMPLE, DONE.
REQ-020 IDLE/DONE + start -> APPLY; index counter cleared to 0 and signature cleared to 0 on the same edge.
REQ-021 APPLY lasts exactly 1+SETTLE cycles, then -> SAMPLE.
REQ-022 SAMPLE lasts 1 cycle: cap_valid=1, cap_data=dut_out, cap_pattern=pattern, signature updated; then -> APPLY with index+1, or -> DONE if index = 2^IN_W-1.
REQ-023 pattern = index (mode 0) or index ^ (index>>1) (mode 1), held constant across APPLY and SAMPLE; pattern = 0 in IDLE/DONE.
REQ-024 mode is sampled on the start edge and held for the sweep; changes mid-sweep are ignored.
REQ-025 Signature update: sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended dut_out, truncated to SIG_W bits.
REQ-026 Per-pattern period is SETTLE+2 cycles; a full sweep is 2^IN_W*(SETTLE+2) cycles from the start edge to the edge that enters DONE.
REQ-027 Index wrap: the counter is IN_W+1 bits wide so that the final pattern 2^IN_W-1 terminates the sweep without aliasing to 0.
REQ-028 start while busy is ignored.
REQ-029 abort in APPLY or SAMPLE -> IDLE next edge; no cap_valid on that edge; signature is retained; done not asserted.
REQ-030 abort and start in the same cycle: abort wins.
REQ-031 done stays high until the next accepted start; signature is stable while in DONE.

Reset
REQ-032 reset asserted -> IDLE immediately, independent of CK; index=0, pattern=0, cap_valid=0, cap_pattern=0, cap_data=0, busy=0, done=0, signature=0.
REQ-033 reset mid-sweep discards all progress; after deassertion no activity occurs until start.

Structure
REQ-034 Shared package holds the FSM state enum and the default POLY constant.
REQ-035 The signature register is a separate sub-module, misr_compactor (params SIG_W, OUT_W, POLY; ports CK, reset, clr, en, din, sig).

Verification
REQ-036 IN_W=6, SETTLE=1, mode 0, dut_out=0: 64 cap_valid pulses with cap_pattern 0..63 in order; done rises 192 cycles after start; signature=0.
REQ-037 IN_W=1, SIG_W=16, dut_out=1: signature=16'h0001 after first SAMPLE and 16'h0003 at DONE.
REQ-038 IN_W=3, mode 1: cap_pattern sequence 0,1,3,2,6,7,5,4.
REQ-039 SETTLE=0 vs SETTLE=3: cap_valid spacing of 2 and 5 cycles respectively; pattern is stable across each interval.
REQ-040 abort during pattern 5: IDLE next cycle, done=0, pattern=0; a new start restarts at pattern 0 with signature cleared.
REQ-041 reset pulsed asynchronously mid-APPLY (between CK edges): all outputs at reset values before the next CK edge; start after release yields a full, correct sweep.
